// File: rtl/uart_receiver.sv
// 8N1 UART receive path: two-flop synchronizer, mid-bit sampling FSM and a
// one-entry valid/ready holding register with framing-error and overrun pulses.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    // state   | meaning
    // S_IDLE  | line idle, waiting for rx_s low
    // S_START | timing to the middle of the start bit
    // S_DATA  | sampling 8 data bits, LSB first
    // S_STOP  | sampling the stop bit, commit on high
    // S_BREAK | stop bit was low, wait for the line to return high
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        r_state;
    logic          r_sync1;
    logic          r_rx_s;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_sh;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_sh      <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt     <= '0;
                        r_sh      <= {r_rx_s, r_sh[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_state <= S_IDLE;
                            // a full register being read on this same edge frees its slot
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= r_sh;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            r_state   <= S_BREAK;
                            r_sh      <= '0;
                            frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_BREAK: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed frame table plus randomized frames, all checked
// every cycle against a frame-level model of the holding register.
module tb_uart_receiver;
    localparam int C      = 16;
    localparam int H      = C / 2;
    localparam int FRAME  = 10 * C;
    localparam int COMMIT = 3 + H + 9 * C;  // tick of the commit edge, counted from the first low drive

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    uart_receiver #(.CLKS_PER_BIT(C)) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .rx_ready(rx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .frame_err(frame_err),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_fe = 1'b0;
    logic       m_ov = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       rdy_pre;
        logic       rdy_com;
        logic       rdy_post;
        int         low_ext;
        int         gap;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_fe;
        logic       exp_ov;
    } row_t;

    function automatic logic [31:0] pack(input logic v, input logic [7:0] d,
                                         input logic fe, input logic ov);
        return {21'd0, v, d, fe, ov};
    endfunction

    function automatic logic [31:0] outs();
        return pack(rx_valid, rx_data, frame_err, overrun);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ev: 0 = nothing, 1 = good stop sampled on this edge, 2 = bad stop sampled
    task automatic step(input int ev, input logic [7:0] b);
        logic       n_valid;
        logic [7:0] n_data;
        logic       n_fe;
        logic       n_ov;
        n_valid = m_valid;
        n_data  = m_data;
        n_fe    = 1'b0;
        n_ov    = 1'b0;
        if (rst) begin
            if (m_valid && rx_ready) n_valid = 1'b0;
            if (ev == 1) begin
                if (!m_valid || rx_ready) begin
                    n_valid = 1'b1;
                    n_data  = b;
                end else begin
                    n_ov = 1'b1;
                end
            end else if (ev == 2) begin
                n_fe = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        m_valid = n_valid;
        m_data  = n_data;
        m_fe    = n_fe;
        m_ov    = n_ov;
        cyc++;
        check($sformatf("cycle %0d {valid,data,ferr,ovr}", cyc), outs(),
              pack(m_valid, m_data, m_fe, m_ov));
    endtask

    task automatic send_frame(input row_t r, input bit rnd, input bit chk);
        for (int t = 1; t <= FRAME; t++) begin
            int idx;
            idx = (t - 1) / C;
            if (idx == 0) rx = 1'b0;
            else if (idx <= 8) rx = r.data[idx-1];
            else rx = r.stop;
            if (rnd) rx_ready = 1'($urandom_range(0, 1));
            else rx_ready = (t < COMMIT) ? r.rdy_pre : (t == COMMIT) ? r.rdy_com : r.rdy_post;
            step((t == COMMIT) ? (r.stop ? 1 : 2) : 0, r.data);
            if (chk && t == COMMIT)
                check($sformatf("commit of %h", r.data), outs(),
                      pack(r.exp_valid, r.exp_data, r.exp_fe, r.exp_ov));
        end
        for (int t = 0; t < r.low_ext; t++) begin
            rx = 1'b0;
            rx_ready = rnd ? 1'($urandom_range(0, 1)) : r.rdy_post;
            step(0, 8'h00);
        end
        for (int t = 0; t < r.gap; t++) begin
            rx = 1'b1;
            rx_ready = rnd ? 1'($urandom_range(0, 1)) : r.rdy_post;
            step(0, 8'h00);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        row_t tbl[9];
        row_t r;

        tbl[0] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 0,  20, 1'b1, 8'h3C, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 40, 20, 1'b0, 8'h3C, 1'b1, 1'b0};
        tbl[2] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 0,  20, 1'b1, 8'h5A, 1'b0, 1'b0};
        tbl[3] = '{8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 0,  20, 1'b1, 8'h11, 1'b0, 1'b0};
        tbl[4] = '{8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 0,  20, 1'b1, 8'h11, 1'b0, 1'b1};
        tbl[5] = '{8'h99, 1'b1, 1'b0, 1'b1, 1'b0, 0,  20, 1'b1, 8'h99, 1'b0, 1'b0};
        tbl[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 0,  16, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[7] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 0,  16, 1'b1, 8'hFF, 1'b0, 1'b0};
        tbl[8] = '{8'h81, 1'b1, 1'b1, 1'b1, 1'b1, 0,  20, 1'b1, 8'h81, 1'b0, 1'b0};

        #3 rst = 1'b0;
        #1 check("reset outputs", outs(), pack(1'b0, 8'h00, 1'b0, 1'b0));
        repeat (3) step(0, 8'h00);
        rst = 1'b1;
        repeat (5) step(0, 8'h00);

        // single byte, consumer not ready
        r = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 0, 20, 1'b1, 8'hA5, 1'b0, 1'b0};
        send_frame(r, 1'b0, 1'b1);
        check("A5 held", outs(), pack(1'b1, 8'hA5, 1'b0, 1'b0));
        rx_ready = 1'b1;
        step(0, 8'h00);
        rx_ready = 1'b0;
        check("one-cycle ready clears valid", outs(), pack(1'b0, 8'hA5, 1'b0, 1'b0));
        step(0, 8'h00);

        // glitch shorter than half a bit
        rx = 1'b0;
        repeat (4) step(0, 8'h00);
        rx = 1'b1;
        repeat (20) step(0, 8'h00);
        check("glitch ignored", outs(), pack(1'b0, 8'hA5, 1'b0, 1'b0));

        for (int i = 0; i < 9; i++) send_frame(tbl[i], 1'b0, 1'b1);

        // reset in the middle of data bit 4 of 0xC3
        r.data = 8'hC3;
        rx_ready = 1'b0;
        for (int t = 1; t <= 5 * C + 8; t++) begin
            int idx;
            idx = (t - 1) / C;
            rx = (idx == 0) ? 1'b0 : r.data[idx-1];
            step(0, 8'h00);
        end
        #2 rst = 1'b0;
        rx = 1'b1;
        #1 check("async reset mid-frame", outs(), pack(1'b0, 8'h00, 1'b0, 1'b0));
        m_valid = 1'b0;
        m_data  = 8'h00;
        repeat (4) step(0, 8'h00);
        rst = 1'b1;
        repeat (10) step(0, 8'h00);
        r = '{8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 0, 20, 1'b1, 8'h7E, 1'b0, 1'b0};
        send_frame(r, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            r.data    = 8'($urandom);
            r.stop    = ($urandom_range(0, 5) != 0);
            r.low_ext = r.stop ? 0 : int'($urandom_range(0, 30));
            r.gap     = r.stop ? int'($urandom_range(0, 20)) : int'($urandom_range(4, 20));
            send_frame(r, 1'b1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
